// File: rtl/alu_muldiv.sv
// alu_muldiv: multi-cycle execute-stage ALU with shifts and RV32M-style
// multiply, divide and remainder. Valid/ready on both sides; the result and
// the lt/ltu/zero flags are held in registers until the consumer takes them.
// Optional build macro ALU_MUL_EARLY_EXIT_EN: multiply stops as soon as the
// remaining multiplier bits are all zero (same result, shorter latency).
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             lt,
  output logic             ltu
);

  localparam int SH_W = $clog2(WIDTH);

`ifdef ALU_MUL_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLT   = 4'd5;
  localparam logic [3:0] OP_SLTU  = 4'd6;
  localparam logic [3:0] OP_SLL   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIV   = 4'd12;
  localparam logic [3:0] OP_REM   = 4'd14;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state_reg, state_next;
  logic [3:0]         op_reg;
  logic [2*WIDTH-1:0] acc_reg, mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [WIDTH-1:0]   quot_reg, rem_reg, divisor_reg;
  logic               neg_q_reg, neg_r_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   result_reg;
  logic               lt_reg, ltu_reg;

  // Decode of the incoming operation
  logic             accept;
  logic             is_mul_op, is_div_op, is_simple_op, signed_div;
  logic             div_by_zero, div_ovf, quick_op;
  logic             lt_now, ltu_now;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign accept       = in_valid && in_ready;
  assign is_mul_op    = (op == OP_MUL) || (op == OP_MULHU);
  assign is_div_op    = (op[3:2] == 2'b11);
  assign is_simple_op = !is_mul_op && !is_div_op;
  assign signed_div   = (op == OP_DIV) || (op == OP_REM);
  assign div_by_zero  = (src_b == '0);
  assign div_ovf      = signed_div && (src_a == MOST_NEG) && (src_b == ALL_ONES);
  assign lt_now       = $signed(src_a) < $signed(src_b);
  assign ltu_now      = src_a < src_b;
  assign shamt        = src_b[SH_W-1:0];
  assign mag_a        = (signed_div && src_a[WIDTH-1]) ? -src_a : src_a;
  assign mag_b        = (signed_div && src_b[WIDTH-1]) ? -src_b : src_b;
  // Ops that finish in a single cycle without entering MUL/DIV
  assign quick_op     = is_simple_op
                     || (is_div_op && (div_by_zero || div_ovf))
                     || (is_mul_op && EARLY_EXIT && (src_b == '0));

  // Single-cycle result, used for simple ops and the divide special cases
  logic [WIDTH-1:0] accept_res;
  always_comb begin
    accept_res = '0;
    case (op)
      OP_ADD:  accept_res = src_a + src_b;
      OP_SUB:  accept_res = src_a - src_b;
      OP_AND:  accept_res = src_a & src_b;
      OP_OR:   accept_res = src_a | src_b;
      OP_XOR:  accept_res = src_a ^ src_b;
      OP_SLT:  accept_res = {{(WIDTH-1){1'b0}}, lt_now};
      OP_SLTU: accept_res = {{(WIDTH-1){1'b0}}, ltu_now};
      OP_SLL:  accept_res = src_a << shamt;
      OP_SRL:  accept_res = src_a >> shamt;
      OP_SRA:  accept_res = WIDTH'($signed(src_a) >>> shamt);
      default: begin
        if (is_div_op) begin
          // op[1] selects remainder over quotient
          if (div_by_zero)
            accept_res = op[1] ? src_a : ALL_ONES;
          else
            accept_res = op[1] ? '0 : src_a;
        end
      end
    endcase
  end

  // One shift-add step of the multiplier
  logic [2*WIDTH-1:0] acc_step;
  logic               mul_last;
  logic [WIDTH-1:0]   mul_res;

  assign acc_step = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign mul_last = (cnt_reg == CNT_W'(WIDTH-1))
                 || (EARLY_EXIT && (mplier_reg[WIDTH-1:1] == '0));
  assign mul_res  = (op_reg == OP_MULHU) ? acc_step[2*WIDTH-1:WIDTH]
                                         : acc_step[WIDTH-1:0];

  // One restoring-division step on the operand magnitudes
  logic [WIDTH:0]   rem_shift;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_next, quot_next, div_res;
  logic             div_last;

  assign rem_shift = {rem_reg, quot_reg[WIDTH-1]};
  assign rem_ge    = rem_shift >= {1'b0, divisor_reg};
  assign rem_next  = rem_ge ? WIDTH'(rem_shift - {1'b0, divisor_reg})
                            : rem_shift[WIDTH-1:0];
  assign quot_next = {quot_reg[WIDTH-2:0], rem_ge};
  assign div_last  = (cnt_reg == CNT_W'(WIDTH-1));
  // Sign fix-up: quotient negative when signs differ, remainder follows dividend
  assign div_res   = op_reg[1] ? (neg_r_reg ? -rem_next : rem_next)
                               : (neg_q_reg ? -quot_next : quot_next);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (quick_op)       state_next = DONE;
          else if (is_mul_op) state_next = MUL;
          else                state_next = DIV;
        end
      end
      MUL:     if (mul_last)  state_next = DONE;
      DIV:     if (div_last)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
  end

  // Operand capture, iteration datapath and result/flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg      <= '0;
      acc_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      quot_reg    <= '0;
      rem_reg     <= '0;
      divisor_reg <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      cnt_reg     <= '0;
      result_reg  <= '0;
      lt_reg      <= 1'b0;
      ltu_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            op_reg      <= op;
            lt_reg      <= lt_now;
            ltu_reg     <= ltu_now;
            result_reg  <= accept_res;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            mcand_reg   <= {{WIDTH{1'b0}}, src_a};
            mplier_reg  <= src_b;
            quot_reg    <= mag_a;
            rem_reg     <= '0;
            divisor_reg <= mag_b;
            neg_q_reg   <= signed_div && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            neg_r_reg   <= signed_div && src_a[WIDTH-1];
          end
        end
        MUL: begin
          acc_reg    <= acc_step;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + 1'b1;
          if (mul_last) result_reg <= mul_res;
        end
        DIV: begin
          quot_reg <= quot_next;
          rem_reg  <= rem_next;
          cnt_reg  <= cnt_reg + 1'b1;
          if (div_last) result_reg <= div_res;
        end
        default: ;
      endcase
    end
  end

  assign result = result_reg;
  assign zero   = (result_reg == '0);
  assign lt     = lt_reg;
  assign ltu    = ltu_reg;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed vectors with hand-computed results, latencies and
// flags for alu_muldiv at WIDTH=32, including reset mid-divide and
// backpressure in DONE.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] src_a, src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero, lt, ltu;

  int n_checks = 0;
  int n_errors = 0;

`ifdef ALU_MUL_EARLY_EXIT_EN
  localparam int LAT_MUL_B10 = 6;   // multiplier 0x10: top set bit 4
  localparam int LAT_MUL_B3  = 3;   // multiplier 3: top set bit 1
  localparam int LAT_MUL_B0  = 1;   // multiplier 0
`else
  localparam int LAT_MUL_B10 = 33;
  localparam int LAT_MUL_B3  = 33;
  localparam int LAT_MUL_B0  = 33;
`endif

  alu_muldiv #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .lt        (lt),
    .ltu       (ltu)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one operation from IDLE, wait for the result, check it, consume it.
  task automatic do_op(input string tag, input logic [3:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int exp_lat,
                       input logic exp_lt, input logic exp_ltu);
    int lat;
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    op = o; src_a = a; src_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = ~o; src_a = ~a; src_b = ~b;   // operands must already be latched
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat,                 exp_lat);
    check({tag, "_result"},  result,              exp_res);
    check({tag, "_zero"},    {31'd0, zero},       {31'd0, exp_res == 32'd0});
    check({tag, "_lt"},      {31'd0, lt},         {31'd0, exp_lt});
    check({tag, "_ltu"},     {31'd0, ltu},        {31'd0, exp_ltu});
    $display("op=%0d a=0x%08h b=0x%08h result=0x%08h lat=%0d [%s]", o, a, b, result, lat, tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result",    result,             32'd0);
    check("rst_zero",      {31'd0, zero},      32'd1);
    check("rst_lt",        {31'd0, lt},        32'd0);
    check("rst_ltu",       {31'd0, ltu},       32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);

    do_op("sub_5_7", 4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1, 1'b1, 1'b1);

    // Reset in the middle of a signed divide
    op = 4'd12; src_a = 32'hFFFF_FFF9; src_b = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("middiv_busy", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0; #1;
    check("middiv_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("middiv_rst_result",    result,             32'd0);
    check("middiv_rst_zero",      {31'd0, zero},      32'd1);
    check("middiv_rst_lt",        {31'd0, lt},        32'd0);
    check("middiv_rst_ltu",       {31'd0, ltu},       32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("middiv_in_ready",  {31'd0, in_ready},  32'd1);
    check("middiv_out_valid", {31'd0, out_valid}, 32'd0);

    // Simple ops
    do_op("add_zero",  4'd0, 32'd3,          32'hFFFF_FFFD, 32'd0,          1, 1'b0, 1'b1);
    do_op("and",       4'd2, 32'h0000_F0F0,  32'h0000_FF00, 32'h0000_F000,  1, 1'b1, 1'b1);
    do_op("or",        4'd3, 32'h0000_F0F0,  32'h0000_FF00, 32'h0000_FFF0,  1, 1'b1, 1'b1);
    do_op("xor",       4'd4, 32'h0000_F0F0,  32'h0000_FF00, 32'h0000_0FF0,  1, 1'b1, 1'b1);
    do_op("slt",       4'd5, 32'hFFFF_FFFF,  32'd1,         32'd1,          1, 1'b1, 1'b0);
    do_op("sltu",      4'd6, 32'hFFFF_FFFF,  32'd1,         32'd0,          1, 1'b1, 1'b0);
    do_op("sll_wrap",  4'd7, 32'd1,          32'd33,        32'd2,          1, 1'b1, 1'b1);
    do_op("sll_31",    4'd7, 32'd1,          32'd31,        32'h8000_0000,  1, 1'b1, 1'b1);
    do_op("srl",       4'd8, 32'h8000_0000,  32'd4,         32'h0800_0000,  1, 1'b1, 1'b0);
    do_op("sra",       4'd9, 32'h8000_0000,  32'd4,         32'hF800_0000,  1, 1'b1, 1'b0);

    // Multiply
    do_op("mulhu_max", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33,          1'b0, 1'b0);
    do_op("mul_x10",   4'd10, 32'h0001_2345, 32'h0000_0010, 32'h0012_3450, LAT_MUL_B10, 1'b0, 1'b0);
    do_op("mul_9x3",   4'd10, 32'd9,         32'd3,         32'd27,        LAT_MUL_B3,  1'b0, 1'b0);
    do_op("mul_x0",    4'd10, 32'd7,         32'd0,         32'd0,         LAT_MUL_B0,  1'b0, 1'b0);

    // Divide / remainder
    do_op("div_m7_2",  4'd12, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 1'b1, 1'b0);
    do_op("rem_m7_2",  4'd14, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 1'b1, 1'b0);
    do_op("div_7_m2",  4'd12, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1'b0, 1'b1);
    do_op("rem_7_m2",  4'd14, 32'd7,         32'hFFFF_FFFE, 32'd1,         33, 1'b0, 1'b1);
    do_op("divu_100_7",4'd13, 32'd100,       32'd7,         32'd14,        33, 1'b0, 1'b0);
    do_op("remu_100_7",4'd15, 32'd100,       32'd7,         32'd2,         33, 1'b0, 1'b0);
    do_op("divu_big",  4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33, 1'b1, 1'b1);
    do_op("remu_big",  4'd15, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 1'b1, 1'b1);

    // Divide corner cases
    do_op("div_by0",   4'd12, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, 1'b0, 1'b0);
    do_op("rem_by0",   4'd14, 32'd5,         32'd0,         32'd5,         1, 1'b0, 1'b0);
    do_op("divu_by0",  4'd13, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, 1'b0, 1'b0);
    do_op("remu_by0",  4'd15, 32'd5,         32'd0,         32'd5,         1, 1'b0, 1'b0);
    do_op("div_ovf",   4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b1, 1'b1);
    do_op("rem_ovf",   4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 1'b1, 1'b1);

    // Backpressure: result held in DONE while in_valid is ignored
    op = 4'd4; src_a = 32'h0000_F0F0; src_b = 32'h0000_FF00; in_valid = 1'b1;
    @(posedge clk); #1;
    op = 4'd0; src_a = 32'd1; src_b = 32'd1;   // keep in_valid high: must be ignored
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready",  {31'd0, in_ready},  32'd0);
      check("bp_result",    result,             32'h0000_0FF0);
      @(posedge clk); #1;
    end
    $display("op=4 backpressure held 10 cycles result=0x%08h", result);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_consume_out_valid", {31'd0, out_valid}, 32'd0);
    check("bp_consume_in_ready",  {31'd0, in_ready},  32'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_not_queued", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised, multi-cycle successor to the single-cycle datapath ALU; adds shifts plus RV32M-style multiply, divide and remainder.
- Sits in the execute stage of the multi-cycle core.
- Operand acceptance and result delivery use valid/ready handshakes, so the controller stalls on long operations.
- Result and flags are registered and held until consumed.

Parameters:
- WIDTH, 32: operand/result width in bits; must be a power of 2, at least 8.
- CNT_W, $clog2(WIDTH)+1: iteration counter width; derived, do not override.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and op valid
- in_ready  output  1  block can accept a new operation
- op  input  4  operation select (encoding below)
- src_a  input  WIDTH  operand A
- src_b  input  WIDTH  operand B
- out_valid  output  1  result registers hold a valid result
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  operation result
- zero  output  1  result == 0
- lt  output  1  signed src_a < src_b, captured at accept
- ltu  output  1  unsigned src_a < src_b, captured at accept

Behaviour:
- Op encoding:
  - 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu
  - 7 sll, 8 srl, 9 sra; shift amount is src_b[$clog2(WIDTH)-1:0]
  - 10 mul (low WIDTH bits), 11 mulhu (high WIDTH bits, unsigned)
  - 12 div, 13 divu, 14 rem, 15 remu
- States: IDLE, MUL, DIV, DONE.
- in_ready = 1 only in IDLE. An operation is accepted on the clock edge where in_valid && in_ready.
- Ops 0-9 (simple):
  - Result computed combinationally and registered on accept; go to DONE.
  - out_valid rises the cycle after accept (latency 1).
  - slt is true two's-complement signed compare; sltu is unsigned.
- Ops 10-11 (multiply):
  - Shift-add with a 2*WIDTH-bit accumulator, one multiplier bit per cycle.
  - Go to MUL; after exactly WIDTH cycles go to DONE.
  - out_valid asserted WIDTH+1 cycles after accept.
- Ops 12-15 (divide/remainder):
  - Restoring division on operand magnitudes, one quotient bit per cycle, WIDTH cycles in DIV, then DONE.
  - Signed fix-up on entry to DONE: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - Latency WIDTH+1.
- Divide by zero: no iteration; go directly to DONE with latency 1.
  - div/divu result = all ones.
  - rem/remu result = src_a.
- Signed overflow (div/rem, src_a = most-negative value, src_b = -1): latency 1.
  - div result = src_a; rem result = 0.
- DONE:
  - out_valid = 1; result, zero, lt and ltu are held stable.
  - On out_ready, return to IDLE; out_valid falls the next cycle.
  - No new operation is accepted in the cycle a result is consumed; back-to-back throughput is at best 1 operation per 2 cycles.
- Operands are latched on accept; src_a, src_b and op may change freely afterwards.
- in_valid while busy is ignored; it is not queued.
- Reset (asynchronous, any state, including mid-iteration):
  - State goes to IDLE; the operation in flight is discarded.
  - out_valid=0, result=0, zero=1, lt=0, ltu=0, counter=0.
  - in_ready=1 from the first cycle after rst_n deasserts.
- zero is derived from the registered result and is valid whenever out_valid=1.

Optional Feature:
- Macro: ALU_MUL_EARLY_EXIT_EN.
- Defined: MUL exits to DONE on the first cycle where all remaining unprocessed multiplier bits are zero.
  - Latency = 1 + (index of the highest set bit of the multiplier, plus 1); minimum 1 when the multiplier = 0.
  - Result is identical to full iteration.
- Undefined: multiply always takes exactly WIDTH iteration cycles. Division timing is unaffected in both cases.

Test Plan:
- Reset and simple ops: reset mid-DIV → next cycle in_ready=1, out_valid=0. Then sub 5-7 → result 0xFFFFFFFE, lt=1, ltu=1, zero=0, out_valid at +1.
- Signed compare and shift: slt 0xFFFFFFFF vs 1 → result 1, ltu=0; sra 0x80000000 by 4 → result 0xF8000000.
- Multiply timing: mulhu 0xFFFFFFFF × 0xFFFFFFFF → result 0xFFFFFFFE at +33 cycles; mul 0x12345 × 0x10 → result 0x123450.
- Signed divide: div -7/2 → -3 (0xFFFFFFFD); rem -7/2 → -1 at +33 cycles; divu 100/7 → 14; remu 100/7 → 2.
- Corner cases: div 5/0 → 0xFFFFFFFF and rem 5/0 → 5, both at +1; div 0x80000000/-1 → 0x80000000 and rem → 0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → result stable, in_ready=0, in_valid ignored. With ALU_MUL_EARLY_EXIT_EN, mul 9×3 → 27 at +3.
